var_delay_line: RTL

- Runtime-programmable delay line: each enabled input sample reappears on `data_o` exactly D enabled cycles later, with D selected per cycle by `delay_i`.
- Built as a circular buffer with a write pointer and a computed read address. The fixed-depth shift-register delay stays as-is; this block covers pipeline paths whose alignment latency is decided at runtime.
- Adds a stall input and a `valid_o` flag that marks when the output carries real delayed data rather than pre-fill garbage.

---
 rtl/var_delay_line.sv | 106 ++++++++++
 1 files changed

// File: rtl/var_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : var_delay_line
// Brief    : Runtime-programmable delay line built on a circular buffer, with
//            stall and a valid flag that masks pre-fill garbage.
//            Optional flush input enabled by macro DELAY_LINE_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module var_delay_line #(
   parameter int DEPTH_MAX  = 32,
   parameter int DATA_WIDTH = 16,
   parameter int AW         = $clog2(DEPTH_MAX)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [AW:0]           delay_i,
   input  logic [DATA_WIDTH-1:0] data_i,
`ifdef DELAY_LINE_FLUSH_EN
   input  logic                  flush_i,
`endif
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o
);

   localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH_MAX);
   localparam logic [AW:0]   C_ONE     = (AW+1)'(1);
   localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_MAX];

   logic [AW-1:0]         wr_ptr_q,   wr_ptr_d;
   logic [AW:0]           fill_cnt_q, fill_cnt_d;
   logic [DATA_WIDTH-1:0] data_q,     data_d;
   logic                  valid_q,    valid_d;

   logic [AW:0]           d_eff;
   logic [AW-1:0]         rd_addr;
   logic                  mem_we;
   logic                  flush;

`ifdef DELAY_LINE_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   always_comb begin
      if (delay_i == '0) begin
         d_eff = C_ONE;
      end else if (delay_i > C_DEPTH) begin
         d_eff = C_DEPTH;
      end else begin
         d_eff = delay_i;
      end
   end

   // At d_eff == DEPTH_MAX the low bits are zero, so read and write alias;
   // read-before-write then returns the oldest sample.
   assign rd_addr = wr_ptr_q - d_eff[AW-1:0];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      fill_cnt_d = fill_cnt_q;
      data_d     = data_q;
      valid_d    = valid_q;
      mem_we     = 1'b0;
      if (flush) begin
         fill_cnt_d = '0;
         valid_d    = 1'b0;
         data_d     = '0;
      end else if (en) begin
         mem_we     = 1'b1;
         data_d     = mem_q[rd_addr];
         valid_d    = (fill_cnt_q >= d_eff);
         wr_ptr_d   = wr_ptr_q + C_PTR_ONE;
         fill_cnt_d = (fill_cnt_q == C_DEPTH) ? fill_cnt_q : fill_cnt_q + C_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         fill_cnt_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         fill_cnt_q <= fill_cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   // Storage has no reset; fill_cnt alone decides what is trustworthy.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule
`default_nettype wire
